// File: rtl/nibble_serial_adder.sv
// Wide adder that streams one 4-bit nibble per cycle through a single carry-lookahead slice.
// Accept-to-result latency is WIDTH/4 cycles; the result is held with in_ready low until out_ready.

module carry_lookahead_adder (
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       CO
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g = A_in & B_in;
    p = A_in ^ B_in;

    // Every carry is flattened from g/p/C_in so no carry ripples inside the slice.
    c[0] = C_in;
    c[1] = g[0] | (p[0] & C_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & C_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & C_in);

    S  = p ^ c[3:0];
    CO = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             last_nib;

  // Nibble select is a one-hot compare per slice so it stays legal for any WIDTH.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (cnt_q == CW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  carry_lookahead_adder u_cla (
    .A_in (nib_a),
    .B_in (nib_b),
    .C_in (carry_q),
    .S    (nib_s),
    .CO   (nib_co)
  );

  assign last_nib  = (cnt_q == CW'(NIBBLES - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ADD);
  assign S         = s_q;
  assign CO        = co_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A_in;
          b_d     = B_in;
          carry_d = C_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (cnt_q == CW'(n)) begin
            s_d[4*n +: 4] = nib_s;
          end
        end
        carry_d = nib_co;
        if (last_nib) begin
          co_d    = nib_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=32 and WIDTH=4.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, co, busy;
  logic [31:0] a, b, s;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, co4, busy4;
  logic [3:0]  a4, b4, s4;

  int n_checks;
  int n_pass;
  int cyc;
  int deliveries;

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (a),
    .B_in      (b),
    .C_in      (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .CO        (co),
    .busy      (busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .A_in      (a4),
    .B_in      (b4),
    .C_in      (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .S         (s4),
    .CO        (co4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) deliveries <= deliveries + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Launch one 32-bit op from a negedge; return cycles from accept to out_valid.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       output int lat, output int busy_cnt);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [31:0] es, input logic ec);
    int lat, bc;
    chk({tag, "_in_ready"}, in_ready, 1);
    do_op(av, bv, cv, lat, bc);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_S"}, s, es);
    chk({tag, "_CO"}, co, ec);
    @(negedge clk);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv, output int lat);
    a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bc, issued, got;
    int acc[3];
    logic [31:0] ea[3], eb[3], es[3];
    logic        ec_in[3], eco[3];

    n_checks = 0; n_pass = 0; cyc = 0; deliveries = 0;
    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
    in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 1;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_S", s, 0);
    chk("rst_CO", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full carry ripple
    do_op(32'hFFFF_FFFF, 32'h0, 1'b1, lat, bc);
    chk("ripple_latency", lat, 8);
    chk("ripple_busy_cycles", bc, 8);
    chk("ripple_S", s, 32'h0);
    chk("ripple_CO", co, 1);
    @(negedge clk);
    chk("ripple_ready_back", in_ready, 1);
    chk("ripple_valid_drop", out_valid, 0);

    op_check("nocarry", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);
    op_check("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

    // Backpressure: result held, a new operand pulse ignored
    out_ready = 1'b0;
    do_op(32'h7654_3210, 32'h0123_4567, 1'b0, lat, bc);
    chk("bp_latency", lat, 8);
    for (int j = 0; j < 5; j++) begin
      if (j == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1; in_valid = 1; end
      if (j == 3) in_valid = 0;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_S", s, 32'h7777_7777);
      chk("bp_CO", co, 0);
    end
    in_valid = 0;
    deliveries = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_S_kept", s, 32'h7777_7777);
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_new_op", busy, 0);
    chk("bp_deliveries", deliveries, 1);

    // Reset during ADD: three nibbles written, then async abort
    a = 32'hFFFF_FFFF; b = 32'h1; cin = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_partial_S", s, 32'h7777_7000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_S", s, 0);
    chk("mid_rst_CO", co, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_check("post_rst", 32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0);

    // Back-to-back
    ea[0] = 32'h0000_0001; eb[0] = 32'h0000_0002; ec_in[0] = 0; es[0] = 32'h0000_0003; eco[0] = 0;
    ea[1] = 32'hFFFF_0000; eb[1] = 32'h0001_FFFF; ec_in[1] = 0; es[1] = 32'h0000_FFFF; eco[1] = 1;
    ea[2] = 32'hDEAD_BEEF; eb[2] = 32'h2152_4110; ec_in[2] = 1; es[2] = 32'h0000_0000; eco[2] = 1;
    issued = 0; got = 0;
    out_ready = 1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (out_valid) begin
        chk("b2b_S", s, es[got]);
        chk("b2b_CO", co, eco[got]);
        got++;
      end
      if (in_ready) begin
        if (issued < 3) begin
          a = ea[issued]; b = eb[issued]; cin = ec_in[issued]; in_valid = 1;
          acc[issued] = cyc + 1;
          issued++;
        end else begin
          in_valid = 0;
        end
      end
      @(negedge clk);
    end
    in_valid = 0;
    chk("b2b_results", got, 3);
    chk("b2b_interval_1", acc[1] - acc[0], 10);
    chk("b2b_interval_2", acc[2] - acc[1], 10);
    repeat (3) @(negedge clk);

    // Minimum width
    op4(4'h9, 4'h8, 1'b1, lat);
    chk("w4_latency", lat, 1);
    chk("w4_S", s4, 4'h2);
    chk("w4_CO", co4, 1);
    @(negedge clk);
    chk("w4_ready_back", in_ready4, 1);
    for (int i = 0; i < 512; i++) begin
      logic [3:0] av, bv;
      logic       cv;
      logic [4:0] want;
      av = i[3:0]; bv = i[7:4]; cv = i[8];
      want = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
      op4(av, bv, cv, lat);
      chk("w4_sweep", {co4, s4, 8'(lat)}, {want, 8'd1});
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
